// File: rtl/nested_pkt_pkg.sv
// Shared types for the packet assembler and the downstream field-modify stage.
// The packet layout lives here so both stages agree on the field positions.
package nested_pkt_pkg;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
        logic        valid;
    } base_struct_t;

    typedef struct packed {
        base_struct_t base;
        logic [15:0]  id;
        logic [3:0]   cmd;
        logic         ready;
    } nested_struct_t;

    localparam int PKT_W  = $bits(nested_struct_t);
    localparam int NBYTES = (PKT_W + 7) / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/nested_pkt_assembler.sv
// Collects an MSB-first byte stream into one nested_struct_t packet and hands
// it downstream over valid/ready; framing errors are counted with saturation.
module nested_pkt_assembler
    import nested_pkt_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 byte_valid,
    input  logic                 byte_sof,
    input  logic [7:0]           byte_data,
    output logic                 byte_ready,
    output logic                 pkt_valid,
    output nested_struct_t       pkt_data,
    input  logic                 pkt_ready,
    output logic [ERR_W-1:0]     err_count,
    output logic [15:0]          pkt_count
);

    localparam logic [2:0] LAST_CNT = 3'(NBYTES - 1);

    state_t            r_state;
    logic [55:0]       r_sr;
    logic [2:0]        r_cnt;
    logic              r_pkt_valid;
    nested_struct_t    r_pkt_data;
    logic [ERR_W-1:0]  r_err_count;
    logic [15:0]       r_pkt_count;
    logic              w_accept;
    logic              w_err_event;

    // Handshake readiness is a pure decode of the registered state
    assign byte_ready = (r_state != HOLD);
    assign w_accept   = byte_valid && byte_ready;

    // Framing error: stray byte while idle, or sof restarting a partial packet
    always_comb begin
        w_err_event = 1'b0;
        if (w_accept) begin
            if (r_state == IDLE) begin
                w_err_event = !byte_sof;
            end else if (r_state == COLLECT) begin
                w_err_event = byte_sof;
            end else begin
                w_err_event = 1'b0;
            end
        end else begin
            w_err_event = 1'b0;
        end
    end

    // Packet framing FSM with shift register, output packet and hand-off count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sr        <= 56'd0;
            r_cnt       <= 3'd0;
            r_pkt_valid <= 1'b0;
            r_pkt_data  <= '0;
            r_pkt_count <= 16'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && byte_sof) begin
                        r_sr    <= {48'd0, byte_data};
                        r_cnt   <= 3'd1;
                        r_state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (w_accept) begin
                        if (byte_sof) begin
                            r_sr  <= {48'd0, byte_data};
                            r_cnt <= 3'd1;
                        end else if (r_cnt == LAST_CNT) begin
                            // Top two bits of the first byte fall off here
                            r_pkt_data  <= nested_struct_t'({r_sr[53:0], byte_data});
                            r_pkt_valid <= 1'b1;
                            r_cnt       <= 3'd0;
                            r_state     <= HOLD;
                        end else begin
                            r_sr  <= {r_sr[47:0], byte_data};
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                end
                HOLD: begin
                    if (pkt_ready) begin
                        r_pkt_valid <= 1'b0;
                        r_pkt_count <= r_pkt_count + 16'd1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= 3'd0;
                    r_pkt_valid <= 1'b0;
                end
            endcase
        end
    end

    // Saturating framing-error counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (w_err_event && (r_err_count != '1)) begin
            r_err_count <= r_err_count + ERR_W'(1);
        end
    end

    assign pkt_valid = r_pkt_valid;
    assign pkt_data  = r_pkt_data;
    assign err_count = r_err_count;
    assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_nested_pkt_assembler.sv
// Self-checking bench: vector table, hand sequences and random traffic
// compared against a queue-based packet model.
module tb_nested_pkt_assembler;
    import nested_pkt_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           byte_valid, byte_sof, pkt_ready;
    logic [7:0]     byte_data;
    logic           byte_ready, pkt_valid;
    nested_struct_t pkt_data;
    logic [7:0]     err_count;
    logic [15:0]    pkt_count;

    int checks = 0;
    int failures = 0;

    // Model state: bytes of the packet in progress, held packet, counters
    logic [7:0]  m_q[$];
    bit          m_hold;
    logic [61:0] m_data;
    int          m_err;
    logic [15:0] m_pc;

    nested_pkt_assembler #(.ERR_W(8)) dut (
        .clk(clk), .rst(rst),
        .byte_valid(byte_valid), .byte_sof(byte_sof), .byte_data(byte_data),
        .byte_ready(byte_ready), .pkt_valid(pkt_valid), .pkt_data(pkt_data),
        .pkt_ready(pkt_ready), .err_count(err_count), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_hold = 1'b0;
        m_data = 62'd0;
        m_err  = 0;
        m_pc   = 16'd0;
    endtask

    function automatic void count_err();
        if (m_err < 255) m_err++;
    endfunction

    task automatic model_update(input logic v, input logic s, input logic [7:0] d, input logic r);
        logic [63:0] w;
        if (m_hold) begin
            if (r) begin
                m_hold = 1'b0;
                m_pc   = m_pc + 16'd1;
            end
        end else if (v) begin
            if (s) begin
                if (m_q.size() > 0) count_err();
                m_q.delete();
                m_q.push_back(d);
            end else if (m_q.size() == 0) begin
                count_err();
            end else begin
                m_q.push_back(d);
            end
            if (m_q.size() == NBYTES) begin
                w = 64'd0;
                foreach (m_q[i]) w = {w[55:0], m_q[i]};
                m_data = w[61:0];
                m_hold = 1'b1;
                m_q.delete();
            end
        end
    endtask

    task automatic compare_all();
        chk("byte_ready", 64'(byte_ready), 64'(!m_hold));
        chk("pkt_valid", 64'(pkt_valid), 64'(m_hold));
        if (m_hold) chk("pkt_data", 64'(pkt_data), 64'(m_data));
        chk("err_count", 64'(err_count), 64'(m_err));
        chk("pkt_count", 64'(pkt_count), 64'(m_pc));
    endtask

    task automatic step(input logic v, input logic s, input logic [7:0] d, input logic r);
        byte_valid = v;
        byte_sof   = s;
        byte_data  = d;
        pkt_ready  = r;
        @(posedge clk);
        model_update(v, s, d, r);
        #1;
        compare_all();
    endtask

    task automatic send_pkt(input logic [63:0] bytes, input logic r);
        for (int i = 0; i < NBYTES; i++) begin
            step(1'b1, (i == 0), bytes[63 - 8*i -: 8], r);
        end
    endtask

    typedef struct {
        logic       v;
        logic       sof;
        logic [7:0] data;
        logic       rdy;
        logic       e_bready;
        logic       e_pvalid;
        logic [7:0] e_err;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [7:0] bseq[8];
        tbl[0]  = '{1'b1, 1'b0, 8'hAA, 1'b1, 1'b1, 1'b0, 8'd1};
        tbl[1]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'd1};
        bseq = '{8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE};
        for (int i = 1; i < 8; i++) begin
            tbl[i+1] = '{1'b1, 1'b0, bseq[i], 1'b0, (i != 7), (i == 7), 8'd1};
        end
        tbl[9]  = '{1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 8'd1};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd1};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'd1};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'd1};

        rst = 1'b1;
        byte_valid = 1'b0; byte_sof = 1'b0; byte_data = 8'h00; pkt_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_byte_ready", 64'(byte_ready), 64'd1);
        chk("reset_pkt_valid", 64'(pkt_valid), 64'd0);
        chk("reset_pkt_data", 64'(pkt_data), 64'd0);
        chk("reset_err", 64'(err_count), 64'd0);
        chk("reset_pkt_count", 64'(pkt_count), 64'd0);
        rst = 1'b0;

        // Stray byte, basic packet, backpressure with an ignored byte, handshake
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].v, tbl[i].sof, tbl[i].data, tbl[i].rdy);
            chk("tbl_byte_ready", 64'(byte_ready), 64'(tbl[i].e_bready));
            chk("tbl_pkt_valid", 64'(pkt_valid), 64'(tbl[i].e_pvalid));
            chk("tbl_err", 64'(err_count), 64'(tbl[i].e_err));
            if (i >= 8 && i <= 10) begin
                chk("basic_pkt_data", 64'(pkt_data), 64'h0012_3456_789A_BCDE);
            end
            if (i == 8) begin
                chk("field_addr", 64'(pkt_data.base.addr), 64'h00);
                chk("field_id", 64'(pkt_data.id), 64'hD5E6);
                chk("field_cmd", 64'(pkt_data.cmd), 64'hF);
                chk("field_ready", 64'(pkt_data.ready), 64'h0);
            end
        end
        chk("basic_pkt_count", 64'(pkt_count), 64'd1);

        // Early sof after three bytes, then a full all-ones packet
        step(1'b1, 1'b1, 8'h11, 1'b0);
        step(1'b1, 1'b0, 8'h22, 1'b0);
        step(1'b1, 1'b0, 8'h33, 1'b0);
        send_pkt(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        chk("early_sof_err", 64'(err_count), 64'd2);
        chk("early_sof_data", 64'(pkt_data), 64'h3FFF_FFFF_FFFF_FFFF);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("early_sof_count", 64'(pkt_count), 64'd2);

        // Asynchronous reset after five bytes, checked before the next edge
        for (int i = 0; i < 5; i++) step(1'b1, (i == 0), 8'(i + 3), 1'b1);
        byte_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("arst_pkt_valid", 64'(pkt_valid), 64'd0);
        chk("arst_byte_ready", 64'(byte_ready), 64'd1);
        chk("arst_err", 64'(err_count), 64'd0);
        chk("arst_pkt_count", 64'(pkt_count), 64'd0);
        chk("arst_pkt_data", 64'(pkt_data), 64'd0);
        #1;
        rst = 1'b0;
        model_reset();
        send_pkt(64'hA1B2_C3D4_E5F6_0718, 1'b0);
        chk("post_rst_data", 64'(pkt_data), 64'h21B2_C3D4_E5F6_0718);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Error counter saturation
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 8'hAA, 1'b1);
        chk("err_saturated", 64'(err_count), 64'd255);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 11) == 0),
                 8'($urandom), ($urandom_range(0, 4) < 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
